// File: rtl/mac4_accum.sv
// Four-lane signed MAC: accumulates NUM_TERMS a*w products per lane with saturation on every add.
// Results and acc_ready appear one edge after the last accepted term; no backpressure, bubbles hold state.
module mac4_accum #(
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 21,
   parameter int NUM_TERMS = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] a0,
   input  logic signed [DATA_W-1:0] a1,
   input  logic signed [DATA_W-1:0] a2,
   input  logic signed [DATA_W-1:0] a3,
   input  logic signed [DATA_W-1:0] w0,
   input  logic signed [DATA_W-1:0] w1,
   input  logic signed [DATA_W-1:0] w2,
   input  logic signed [DATA_W-1:0] w3,
   output logic                     busy,
   output logic                     acc_ready,
   output logic signed [ACC_W-1:0]  sum0,
   output logic signed [ACC_W-1:0]  sum1,
   output logic signed [ACC_W-1:0]  sum2,
   output logic signed [ACC_W-1:0]  sum3
);

   localparam int CNT_W = $clog2(NUM_TERMS);
   localparam int P_W   = 2 * DATA_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TERMS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE,
      S_ACCUM
   } state_t;

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         cnt, cnt_nxt;
   logic                     rdy_q, rdy_nxt;
   logic                     busy_q, busy_nxt;

   logic signed [DATA_W-1:0] a_l     [4];
   logic signed [DATA_W-1:0] w_l     [4];
   logic signed [P_W-1:0]    prod    [4];
   logic signed [ACC_W:0]    p_ext   [4];
   logic signed [ACC_W:0]    s_ext   [4];
   logic signed [ACC_W-1:0]  p_sat   [4];
   logic signed [ACC_W-1:0]  s_sat   [4];
   logic signed [ACC_W-1:0]  acc     [4];
   logic signed [ACC_W-1:0]  acc_nxt [4];
   logic signed [ACC_W-1:0]  sum_q   [4];
   logic signed [ACC_W-1:0]  sum_nxt [4];

   // One guard bit above ACC_W: overflow shows up as the top two bits disagreeing.
   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] x);
      if (x[ACC_W] != x[ACC_W-1])
         sat_acc = {x[ACC_W], {(ACC_W-1){~x[ACC_W]}}};
      else
         sat_acc = x[ACC_W-1:0];
   endfunction

   always_comb begin
      a_l[0] = a0;
      a_l[1] = a1;
      a_l[2] = a2;
      a_l[3] = a3;
      w_l[0] = w0;
      w_l[1] = w1;
      w_l[2] = w2;
      w_l[3] = w3;
   end

   // Lane datapath: full-width product, sign-extended, saturating add to the running sum.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         prod[i]  = $signed({{DATA_W{a_l[i][DATA_W-1]}}, a_l[i]})
                  * $signed({{DATA_W{w_l[i][DATA_W-1]}}, w_l[i]});
         p_ext[i] = {{(ACC_W+1-P_W){prod[i][P_W-1]}}, prod[i]};
         s_ext[i] = {acc[i][ACC_W-1], acc[i]} + p_ext[i];
         p_sat[i] = sat_acc(p_ext[i]);
         s_sat[i] = sat_acc(s_ext[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         rdy_q  <= 1'b0;
         busy_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            acc[i]   <= '0;
            sum_q[i] <= '0;
         end
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         rdy_q  <= rdy_nxt;
         busy_q <= busy_nxt;
         for (int i = 0; i < 4; i++) begin
            acc[i]   <= acc_nxt[i];
            sum_q[i] <= sum_nxt[i];
         end
      end
   end

   // clear outranks the last-term completion, so an aborted window never pulses.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rdy_nxt   = 1'b0;
      acc_nxt   = acc;
      sum_nxt   = sum_q;
      if (clear) begin
         if (in_valid) begin
            state_nxt = S_ACCUM;
            cnt_nxt   = CNT_ONE;
            acc_nxt   = p_sat;
         end else begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            for (int i = 0; i < 4; i++) acc_nxt[i] = '0;
         end
      end else if (in_valid) begin
         case (state)
            S_IDLE: begin
               state_nxt = S_ACCUM;
               cnt_nxt   = CNT_ONE;
               acc_nxt   = p_sat;
            end
            S_ACCUM: begin
               if (cnt == CNT_LAST) begin
                  state_nxt = S_IDLE;
                  cnt_nxt   = '0;
                  rdy_nxt   = 1'b1;
                  sum_nxt   = s_sat;
                  for (int i = 0; i < 4; i++) acc_nxt[i] = '0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
                  acc_nxt = s_sat;
               end
            end
            default: begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
      busy_nxt = (cnt_nxt != '0);
   end

   always_comb begin
      busy      = busy_q;
      acc_ready = rdy_q;
      sum0      = sum_q[0];
      sum1      = sum_q[1];
      sum2      = sum_q[2];
      sum3      = sum_q[3];
   end

endmodule

// File: doc/mac4_accum.md
Name: mac4_accum

Overview:
- Four-lane signed multiply-accumulate stage that sits directly upstream of the ReLU stage.
- Each lane accumulates NUM_TERMS activation×weight products, e.g. one 3x3 kernel window.
- On completion it presents four saturated ACC_W-bit sums and a one-cycle acc_ready pulse.
- sum0..sum3 and acc_ready connect directly to the ReLU stage's in0..in3 and in_ready.

Parameters:
DATA_W, 8, width of signed activations and weights
ACC_W, 21, width of signed accumulators and outputs (matches the ReLU stage input width)
NUM_TERMS, 9, products accumulated per window (legal range 2..32)

Ports:
clk  input  1  rising-edge clock; single clock domain
rst  input  1  synchronous, active-high reset
clear  input  1  synchronous abort of the partial window
in_valid  input  1  a0..a3 and w0..w3 carry a valid term this cycle
a0,a1,a2,a3  input  DATA_W each  signed activations, one per lane
w0,w1,w2,w3  input  DATA_W each  signed weights, one per lane
busy  output  1  high while a partial window is held (cnt != 0)
acc_ready  output  1  one-cycle pulse; sum0..sum3 valid this cycle
sum0,sum1,sum2,sum3  output  ACC_W each  signed saturated window results

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all registers clear on a clk edge with rst=1. Values after reset:
  - acc0..3 = 0, cnt = 0
  - sum0..3 = 0, acc_ready = 0, busy = 0
- Priority order per cycle: rst, then clear, then in_valid.
- Product: p_i = a_i*w_i, full 2*DATA_W signed result, sign-extended to ACC_W+1 before the add.
- Saturating add: s_i = acc_i + p_i, clamped to the range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Clamping is applied on every add, not only at the end of the window.
- Term counter cnt runs 0..NUM_TERMS-1 and advances only on accepted terms (in_valid=1).
- States:
  - IDLE (cnt=0): an accepted term loads acc_i = sat(p_i) and sets cnt = 1.
  - ACCUM (0 < cnt < NUM_TERMS-1): an accepted term sets acc_i = s_i and increments cnt.
  - Last term (cnt = NUM_TERMS-1 and in_valid=1), all in that one edge:
    - sum_i <= s_i and acc_ready <= 1
    - acc_i <= 0 and cnt <= 0 (return to IDLE)
- Latency: acc_ready rises on the clock edge after the cycle in which the last term is accepted.
- acc_ready is high for exactly one cycle per completed window.
- in_valid=0 cycles are bubbles: no state change, and no timeout.
- Back-to-back windows: a term in the cycle after the last term is the first term of the next window, with no dead cycle.
  - The sum outputs keep the previous result until the next window completes.
- sum0..3 hold their value at all times other than a completion edge or reset.
- clear=1 discards the partial window (acc and cnt).
  - If in_valid=1 in the same cycle, that term is loaded as the first term of a new window (acc_i = sat(p_i), cnt = 1).
  - Otherwise cnt = 0.
  - clear never changes sum0..3 and never generates acc_ready.
- clear together with the last term: clear wins. No acc_ready is produced and that term starts a new window.
- rst in the middle of a window discards all partial state. No acc_ready is produced for the aborted window.
- busy = (cnt != 0), registered alongside cnt.
- All four lanes share cnt and the control logic; lanes differ only in data.

Test Plan:
1. Reset, then idle 5 cycles -> sum0..3 = 0, acc_ready = 0, busy = 0 throughout.
2. Windows with bubbles: NUM_TERMS=9; lane0 a=1..9, w=2; lane1 a=-3, w=5 for all terms; in_valid toggled 1,0,1,... -> exactly one acc_ready pulse, one cycle after the 9th accepted term; sum0=90, sum1=-135; lanes 2,3 with a=0 give 0; busy high from the 1st accept until the completion edge.
3. Saturation with ACC_W=16: all lanes a=127, w=127 for 9 terms -> sum=32767; a=-128, w=127 -> sum=-32768; no wrap in any intermediate cycle.
4. Two back-to-back windows, in_valid held high 18 cycles:
   - window 1: lane0 a=1, w=1 -> sum0=9
   - window 2: lane0 a=2, w=1 -> sum0=18
   - acc_ready pulses exactly 9 cycles apart; sum0 stays 9 between the pulses.
5. Clear mid-window:
   - 4 terms a=10, w=1, then clear with in_valid=1 and a=1, w=1, then 8 more terms a=1, w=1 -> sum0=9, not 49.
   - clear asserted on the 9th term -> no acc_ready pulse.
6. rst asserted after 5 terms, then a full 9-term window a=3, w=3 -> no pulse for the aborted window; sum0=81; sums read 0 between the reset and the new completion.
